// File: rtl/aes_ks_pkg.sv
// Shared definitions for the sequential AES key schedule: key-size derived
// constants, FSM state type, GF(2^8) helpers and the forward S-box.
// AES_KS_DECRYPT_EN additionally provides the InvMixColumns column helper.
package aes_ks_pkg;

  typedef enum logic {
    IDLE,
    EXPAND
  } ks_state_e;

  // Key words for a given cipher key width.
  function automatic int unsigned ks_nk(input int unsigned key_size);
    return key_size / 32;
  endfunction

  // Number of cipher rounds.
  function automatic int unsigned ks_nr(input int unsigned key_size);
    return ks_nk(key_size) + 6;
  endfunction

  // Total schedule words.
  function automatic int unsigned ks_nw(input int unsigned key_size);
    return 4 * (ks_nr(key_size) + 1);
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  // Forward S-box; element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef AES_KS_DECRYPT_EN
  // InvMixColumns on one 32-bit column, MSB byte = row 0.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]   = col[31-8*r -: 8];
      x2     = xtime(a[r]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[r]  = x8 ^ a[r];
      m11[r] = x8 ^ x2 ^ a[r];
      m13[r] = x8 ^ x4 ^ a[r];
      m14[r] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction
`endif

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_subword
  import aes_ks_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                   SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key schedule for AES-128/192/256. One schedule word is
// produced per clock through a single shared SubWord unit; round keys are
// served from the word store through a registered indexed read port.
// Optional feature macro: AES_KS_DECRYPT_EN (equivalent-inverse round keys
// via InvMixColumns on the read path, selected by rk_inv).
module aes_key_schedule_seq
  import aes_ks_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_SIZE-1:0] key,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [3:0]          rk_idx,
  input  logic                rk_inv,
  output logic [127:0]        rk
);

  localparam int unsigned NK = ks_nk(KEY_SIZE);
  localparam int unsigned NR = ks_nr(KEY_SIZE);
  localparam int unsigned NW = ks_nw(KEY_SIZE);
  localparam int unsigned IW = 6;

  localparam logic [IW-1:0] NK_W     = IW'(NK);
  localparam logic [IW-1:0] LAST_W   = IW'(NW - 1);
  localparam logic [2:0]    MOD_LAST = 3'(NK - 1);
  localparam logic [3:0]    NR_W     = 4'(NR);

  if (!(KEY_SIZE == 128 || KEY_SIZE == 192 || KEY_SIZE == 256)) begin : g_bad_key_size
    $error("aes_key_schedule_seq: KEY_SIZE must be 128, 192 or 256");
  end

  ks_state_e     r_state;
  ks_state_e     w_state_nxt;
  logic [31:0]   r_words [NW];
  logic [IW-1:0] r_idx;
  logic [2:0]    r_mod;
  logic [7:0]    r_rcon;
  logic          r_done;
  logic          r_keys_valid;
  logic [127:0]  r_rk;

  logic          w_accept;
  logic          w_last;
  logic          w_busy;
  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic [IW-1:0] w_base;
  logic          w_idx_ok;
  logic [127:0]  w_rk_plain;
  logic [127:0]  w_rk_sel;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and FSM-derived strobes.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_accept = start;
        if (start) w_state_nxt = EXPAND;
      end
      EXPAND: begin
        w_busy = 1'b1;
        if (r_idx == LAST_W) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // Recurrence inputs: w[i-1] and w[i-NK]; RotWord only at the start of each NK group.
  assign w_prev   = r_words[r_idx - IW'(1)];
  assign w_back   = r_words[r_idx - NK_W];
  assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // Select the temp word t for the current position within the NK group.
  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0)                  w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_mod == 3'd4) w_temp = w_sub_out;
  end

  assign w_new = w_back ^ w_temp;

  // Word store: key load on accept, one expanded word per EXPAND cycle.
  // NOTE: the store is reset explicitly so an aborted run never leaves
  // readable words from a previous key behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NW; k++) r_words[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NW; k++) begin
        if (w_accept && k < NK)              r_words[k] <= key[KEY_SIZE-1-32*k -: 32];
        else if (w_busy && r_idx == IW'(k)) r_words[k] <= w_new;
      end
    end
  end

  // Word index, mod-NK position, rcon and completion flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_mod        <= '0;
      r_rcon       <= '0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_idx        <= NK_W;
        r_mod        <= '0;
        r_rcon       <= 8'h01;
        r_keys_valid <= 1'b0;
      end else if (w_busy) begin
        r_idx <= r_idx + IW'(1);
        r_mod <= (r_mod == MOD_LAST) ? 3'd0 : r_mod + 3'd1;
        if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
        if (w_last)        r_keys_valid <= 1'b1;
      end
    end
  end

  // Four-word gather for the requested round; out-of-range index reads zero.
  assign w_base     = {rk_idx, 2'b00};
  assign w_idx_ok   = (rk_idx <= NR_W);
  assign w_rk_plain = w_idx_ok ? {r_words[w_base],          r_words[w_base + IW'(1)],
                                  r_words[w_base + IW'(2)], r_words[w_base + IW'(3)]}
                               : 128'h0;

`ifdef AES_KS_DECRYPT_EN
  // Equivalent-inverse key for inner rounds only; first and last stay plain.
  always_comb begin
    w_rk_sel = w_rk_plain;
    if (rk_inv && rk_idx != 4'd0 && rk_idx < NR_W)
      w_rk_sel = {inv_mix_column(w_rk_plain[127:96]), inv_mix_column(w_rk_plain[95:64]),
                  inv_mix_column(w_rk_plain[63:32]),  inv_mix_column(w_rk_plain[31:0])};
  end
`else
  logic w_unused_inv;
  assign w_unused_inv = rk_inv;
  assign w_rk_sel     = w_rk_plain;
`endif

  // Registered round-key output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rk <= '0;
    else     r_rk <= w_rk_sel;
  end

  assign busy       = w_busy;
  assign done       = r_done;
  assign keys_valid = r_keys_valid;
  assign rk         = r_rk;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq: FIPS-197 vectors for all three key
// sizes, start handshake, read-port bounds, mid-run reset and the rk_inv path.
module tb_aes_key_schedule_seq;

  localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2_128  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] RK1_192  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK2_256  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK3_256  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;

  logic         clk;
  logic         rst;
  logic         st128, st192, st256;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic         busy128, busy192, busy256;
  logic         done128, done192, done256;
  logic         kv128, kv192, kv256;
  logic [3:0]   idx128, idx192, idx256;
  logic         inv128, inv192, inv256;
  logic [127:0] rk128, rk192, rk256;

  int n_checks = 0;
  int n_errors = 0;

  aes_key_schedule_seq #(.KEY_SIZE(128)) u_dut128 (
    .clk(clk), .rst(rst), .start(st128), .key(key128), .busy(busy128), .done(done128),
    .keys_valid(kv128), .rk_idx(idx128), .rk_inv(inv128), .rk(rk128));

  aes_key_schedule_seq #(.KEY_SIZE(192)) u_dut192 (
    .clk(clk), .rst(rst), .start(st192), .key(key192), .busy(busy192), .done(done192),
    .keys_valid(kv192), .rk_idx(idx192), .rk_inv(inv192), .rk(rk192));

  aes_key_schedule_seq #(.KEY_SIZE(256)) u_dut256 (
    .clk(clk), .rst(rst), .start(st256), .key(key256), .busy(busy256), .done(done256),
    .keys_valid(kv256), .rk_idx(idx256), .rk_inv(inv256), .rk(rk256));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done128;
      1:       return done192;
      default: return done256;
    endcase
  endfunction

  function automatic logic [127:0] get_rk(input int sel);
    case (sel)
      0:       return rk128;
      1:       return rk192;
      default: return rk256;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       st128 = v;
      1:       st192 = v;
      default: st256 = v;
    endcase
  endtask

  // Called at posedge+1: pulse start, then count edges until done.
  task automatic run_expand(input int sel, input string tag, input int exp_cycles);
    int c;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    c = 0;
    while (!get_done(sel) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, 128'(c), 128'(exp_cycles));
  endtask

  // Present an index, return rk one edge later.
  task automatic read_rk(input int sel, input logic [3:0] idx, input logic inv,
                         output logic [127:0] v);
    case (sel)
      0:       begin idx128 = idx; inv128 = inv; end
      1:       begin idx192 = idx; inv192 = inv; end
      default: begin idx256 = idx; inv256 = inv; end
    endcase
    @(posedge clk); #1;
    v = get_rk(sel);
  endtask

`ifdef AES_KS_DECRYPT_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] model_imc(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = k[127-32*c -: 8]; a1 = k[119-32*c -: 8];
      a2 = k[111-32*c -: 8]; a3 = k[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
      r[119-32*c -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
      r[111-32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
      r[103-32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
    end
    return r;
  endfunction
`endif

  initial begin
    logic [127:0] v;
    int c;

    rst = 1'b1;
    st128 = 1'b0; st192 = 1'b0; st256 = 1'b0;
    key128 = K128; key192 = K192; key256 = K256;
    idx128 = '0; idx192 = '0; idx256 = '0;
    inv128 = 1'b0; inv192 = 1'b0; inv256 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  128'(busy128), 128'd0);
    check("rst_done",  128'(done128), 128'd0);
    check("rst_kv",    128'(kv128),   128'd0);
    check("rst_rk",    rk128,         128'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // AES-192
    run_expand(1, "done192_latency", 46);
    check("kv192_at_done",   128'(kv192),   128'd1);
    check("busy192_at_done", 128'(busy192), 128'd0);
    read_rk(1, 4'd0, 1'b0, v);  check("rk0_192", v, K192[191:64]);
    read_rk(1, 4'd1, 1'b0, v);  check("rk1_192", v, RK1_192);
    read_rk(1, 4'd12, 1'b0, v); check("w51_192", 128'(v[31:0]), 128'h01002202);
    read_rk(1, 4'd13, 1'b0, v); check("rk13_192_oob", v, 128'd0);

    // AES-256
    run_expand(2, "done256_latency", 52);
    check("kv256_at_done", 128'(kv256), 128'd1);
    read_rk(2, 4'd0, 1'b0, v);  check("rk0_256", v, K256[255:128]);
    read_rk(2, 4'd2, 1'b0, v);  check("rk2_256", v, RK2_256);
    read_rk(2, 4'd3, 1'b0, v);  check("rk3_256_subword_only", v, RK3_256);
    read_rk(2, 4'd14, 1'b0, v); check("w59_256", 128'(v[31:0]), 128'h706c631e);
    read_rk(2, 4'd15, 1'b0, v); check("rk15_256_oob", v, 128'd0);

    // AES-128 handshake: stray starts at cycles 5 and 39 carry a zero key.
    key128 = K128; idx128 = 4'd0; inv128 = 1'b0;
    st128 = 1'b1;
    @(posedge clk); #1;
    st128 = 1'b0;
    check("hs_busy_after_accept", 128'(busy128), 128'd1);
    c = 0;
    while (c < 40) begin
      @(posedge clk); #1;
      c++;
      st128 = 1'b0; key128 = K128;
      if (c == 5 || c == 39) begin
        check($sformatf("hs_busy_c%0d", c), 128'(busy128), 128'd1);
        st128 = 1'b1; key128 = '0;
      end
      if (c == 39) check("hs_done_low_c39", 128'(done128), 128'd0);
    end
    check("hs_done_c40", 128'(done128), 128'd1);
    check("hs_busy_c40", 128'(busy128), 128'd0);
    check("hs_kv_c40",   128'(kv128),   128'd1);
    // Restart on the done cycle and read round 10 on the same edge.
    key128 = K128; st128 = 1'b1; idx128 = 4'd10;
    @(posedge clk); #1;
    c++;
    st128 = 1'b0;
    check("hs_done_single_pulse", 128'(done128), 128'd0);
    check("hs_restart_busy",      128'(busy128), 128'd1);
    check("hs_restart_kv_low",    128'(kv128),   128'd0);
    check("hs_rk10_first_run",    rk128,         RK10_128);
    while (!done128 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("hs_second_done_c81", 128'(c), 128'd81);

    read_rk(0, 4'd1, 1'b0, v);  check("rk1_128", v, RK1_128);
    check("w4_128", 128'(v[127:96]), 128'ha0fafe17);
    read_rk(0, 4'd2, 1'b0, v);  check("rk2_128", v, RK2_128);
    read_rk(0, 4'd10, 1'b0, v); check("rk10_128", v, RK10_128);
    read_rk(0, 4'd11, 1'b0, v); check("rk11_128_oob", v, 128'd0);
    read_rk(0, 4'd15, 1'b0, v); check("rk15_128_oob", v, 128'd0);

    // rk_inv path
    read_rk(0, 4'd0, 1'b1, v);  check("inv_rk0_plain", v, K128);
    read_rk(0, 4'd10, 1'b1, v); check("inv_rk10_plain", v, RK10_128);
`ifdef AES_KS_DECRYPT_EN
    read_rk(0, 4'd1, 1'b1, v);  check("inv_rk1_imc", v, model_imc(RK1_128));
    read_rk(0, 4'd2, 1'b1, v);  check("inv_rk2_imc", v, model_imc(RK2_128));
`else
    read_rk(0, 4'd1, 1'b1, v);  check("inv_rk1_ignored", v, RK1_128);
    read_rk(0, 4'd2, 1'b1, v);  check("inv_rk2_ignored", v, RK2_128);
`endif
    read_rk(0, 4'd0, 1'b0, v);  check("rk0_128", v, K128);

    // Reset mid-run at cycle 20.
    st128 = 1'b1;
    @(posedge clk); #1;
    st128 = 1'b0;
    c = 0;
    while (c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("mid_busy_before_rst", 128'(busy128), 128'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 128'(busy128), 128'd0);
    check("mid_rst_done", 128'(done128), 128'd0);
    check("mid_rst_kv",   128'(kv128),   128'd0);
    check("mid_rst_rk",   rk128,         128'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    read_rk(0, 4'd1, 1'b0, v);  check("mid_store_cleared", v, 128'd0);
    check("mid_no_done", 128'(done128), 128'd0);
    run_expand(0, "mid_rerun_latency", 40);
    check("mid_rerun_kv", 128'(kv128), 128'd1);
    read_rk(0, 4'd1, 1'b0, v);  check("mid_rerun_rk1", v, RK1_128);
    read_rk(0, 4'd10, 1'b0, v); check("mid_rerun_rk10", v, RK10_128);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
